// File: rtl/led_pkg.sv
// Shared constants and FSM encoding for the LED driver family.
// Imported by the fade driver, its PWM slice and the pattern generators.
package led_pkg;

    localparam int PWM_BITS_DFLT = 8;
    localparam int CLK_HZ        = 50_000_000;
    localparam int ONE_SEC       = CLK_HZ;
    localparam int HALF_SEC      = CLK_HZ / 2;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } fade_state_t;

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM slice: registered pin from counter vs level.
// Full-scale level drives the pin solidly on, with no 1/256 gap.
module led_pwm
    import led_pkg::*;
#(
    parameter int BITS = PWM_BITS_DFLT
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [BITS-1:0] level,
    output logic            pin
);

    logic [BITS-1:0] cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= '0;
            pin <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            pin <= (&level) | (cnt < level);
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// Soft-fade LED driver: linear brightness ramp between off and full on.
// The FSM and step timer live here; the PWM output stage is led_pwm.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int          PWM_BITS  = PWM_BITS_DFLT,
    parameter logic [27:0] RAMP_STEP = 28'd97_656
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                LED_Req,
    output logic                LED_Pin,
    output logic [PWM_BITS-1:0] Level_Out,
    output logic                Busy
);

    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [27:0]         STEP_LAST = RAMP_STEP - 28'd1;

    fade_state_t         state;
    fade_state_t         state_nx;
    logic [PWM_BITS-1:0] level_nx;
    logic [27:0]         step_cnt;
    logic [27:0]         step_nx;
    logic                step_done;

    assign step_done = (step_cnt == STEP_LAST);
    assign Busy      = (state == RAMP_UP) || (state == RAMP_DOWN);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= OFF;
            Level_Out <= '0;
            step_cnt  <= '0;
        end else begin
            state     <= state_nx;
            Level_Out <= level_nx;
            step_cnt  <= step_nx;
        end
    end

    // Direction change takes priority over a completing step.
    always_comb begin
        state_nx = state;
        level_nx = Level_Out;
        step_nx  = '0;
        unique case (state)
            OFF: begin
                if (LED_Req) state_nx = RAMP_UP;
            end
            ON: begin
                if (!LED_Req) state_nx = RAMP_DOWN;
            end
            RAMP_UP: begin
                if (!LED_Req) begin
                    state_nx = RAMP_DOWN;
                end else if (Level_Out == LVL_MAX) begin
                    state_nx = ON;
                end else if (step_done) begin
                    level_nx = Level_Out + 1'b1;
                    if (level_nx == LVL_MAX) state_nx = ON;
                end else begin
                    step_nx = step_cnt + 28'd1;
                end
            end
            RAMP_DOWN: begin
                if (LED_Req) begin
                    state_nx = RAMP_UP;
                end else if (Level_Out == '0) begin
                    state_nx = OFF;
                end else if (step_done) begin
                    level_nx = Level_Out - 1'b1;
                    if (level_nx == '0) state_nx = OFF;
                end else begin
                    step_nx = step_cnt + 28'd1;
                end
            end
        endcase
    end

    led_pwm #(
        .BITS (PWM_BITS)
    ) u_pwm (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .level (Level_Out),
        .pin   (LED_Pin)
    );

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: behavioural model plus directed scenarios.
module tb_led_fade_driver;

    localparam int STEP = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       req   = 1'b0;
    logic       req2  = 1'b0;
    logic       pin, pin2, busy, busy2;
    logic [7:0] lvl, lvl2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    led_fade_driver #(
        .PWM_BITS  (8),
        .RAMP_STEP (28'd4)
    ) dut (
        .CLK       (clk),
        .RSTn      (rst_n),
        .LED_Req   (req),
        .LED_Pin   (pin),
        .Level_Out (lvl),
        .Busy      (busy)
    );

    led_fade_driver #(
        .PWM_BITS  (8),
        .RAMP_STEP (28'd256)
    ) dut_slow (
        .CLK       (clk),
        .RSTn      (rst_n),
        .LED_Req   (req2),
        .LED_Pin   (pin2),
        .Level_Out (lvl2),
        .Busy      (busy2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: brightness walks toward the requested target one unit per
    // STEP cycles; a request flip restarts the step timer.
    typedef struct {
        int level;
        bit moving;
        bit dir;
        int cnt;
        int pwm;
        bit pin;
    } mdl_t;

    mdl_t m = '{default: 0};

    function automatic mdl_t model_step(input mdl_t c, input bit r);
        mdl_t n;
        int   target;
        n        = c;
        target   = r ? 255 : 0;
        n.pin    = (c.level == 255) || (c.pwm < c.level);
        n.pwm    = (c.pwm + 1) % 256;
        if (!c.moving) begin
            if (c.level != target) begin
                n.moving = 1'b1;
                n.dir    = r;
                n.cnt    = 0;
            end
        end else if (r != c.dir) begin
            n.dir = r;
            n.cnt = 0;
        end else if (c.level == target) begin
            n.moving = 1'b0;
        end else begin
            n.cnt = c.cnt + 1;
            if (n.cnt == STEP) begin
                n.cnt   = 0;
                n.level = r ? c.level + 1 : c.level - 1;
                if (n.level == target) n.moving = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= model_step(m, req);
    end

    always @(negedge clk) begin
        chk("model_level", int'(lvl), m.level);
        chk("model_busy", int'(busy), int'(m.moving));
        chk("model_pin", int'(pin), int'(m.pin));
    end

    task automatic wait_lvl(input string name, input bit slow,
                            input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((slow ? int'(lvl2) : int'(lvl)) == target) break;
            @(negedge clk);
        end
        chk(name, slow ? int'(lvl2) : int'(lvl), target);
    endtask

    initial begin
        int hi;
        int peak;

        req = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", int'(lvl), 0);
        chk("rst_pin", int'(pin), 0);
        chk("rst_busy", int'(busy), 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("start_busy", int'(busy), 1);
        chk("start_level", int'(lvl), 0);
        repeat (1019) @(negedge clk);
        chk("ramp_1019_level", int'(lvl), 254);
        chk("ramp_1019_busy", int'(busy), 1);
        @(negedge clk);
        chk("ramp_1020_level", int'(lvl), 255);
        chk("ramp_1020_busy", int'(busy), 0);
        hi = 0;
        repeat (300) begin
            @(negedge clk);
            hi += int'(pin);
        end
        chk("full_on_highs", hi, 300);

        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req = 1'b1;
        wait_lvl("rev_reach10", 1'b0, 10, 200);
        req = 1'b0;
        @(negedge clk);
        chk("rev_hold", int'(lvl), 10);
        chk("rev_busy", int'(busy), 1);
        peak = int'(lvl);
        repeat (39) begin
            @(negedge clk);
            if (int'(lvl) > peak) peak = int'(lvl);
        end
        chk("rev_peak", peak, 10);
        chk("rev_39_level", int'(lvl), 1);
        @(negedge clk);
        chk("rev_40_level", int'(lvl), 0);
        chk("rev_40_busy", int'(busy), 0);

        req = 1'b1;
        wait_lvl("sim_reach20", 1'b0, 20, 200);
        repeat (3) @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("sim_no_step", int'(lvl), 20);
        chk("sim_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        chk("sim_wait_level", int'(lvl), 20);
        @(negedge clk);
        chk("sim_first_dec", int'(lvl), 19);

        req = 1'b1;
        wait_lvl("arst_reach100", 1'b0, 100, 1000);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_level", int'(lvl), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_pin", int'(pin), 0);
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b1;

        req2 = 1'b1;
        wait_lvl("duty_reach64", 1'b1, 64, 70 * 256);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(pin2);
        end
        chk("duty64_highs", hi, 64);
        chk("duty64_busy", int'(busy2), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream stage of the LED pattern generators; consumes their 1-bit on/off request and drives the physical LED pin.
- Replaces hard on/off edges with a linear brightness ramp ("soft fade") using an 8-bit PWM at CLK/256 (195.3 kHz at 50 MHz).
- One instance per LED; sits between pattern generator output and the top-level pin.

Parameters:
- PWM_BITS, 8, PWM resolution; brightness level range 0..2^PWM_BITS-1.
- RAMP_STEP, 28'd97_656, CLK cycles per 1-LSB level change; at 50 MHz a full 0->255 ramp takes about 0.5 s.
- Legal range: RAMP_STEP >= 1.

Ports:
- CLK  input  1  system clock, 50 MHz.
- RSTn  input  1  reset: asynchronous assert, active-low.
- LED_Req  input  1  desired LED state from the pattern generator; 1 = on. Synchronous to CLK.
- LED_Pin  output  1  PWM drive to the LED pin; registered.
- Level_Out  output  PWM_BITS  current brightness level; registered.
- Busy  output  1  1 while a ramp is in progress (RAMP_UP or RAMP_DOWN).

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RSTn.
- While RSTn = 0, all state clears:
  - state = OFF, Level_Out = 0, LED_Pin = 0, Busy = 0, PWM counter = 0, step counter = 0.
  - Reset mid-ramp behaves identically: the partial level is discarded, with no ramp down.
- PWM counter: free-running PWM_BITS-bit counter, 0..255, wraps to 0.
- LED_Pin (registered, one-cycle latency from counter and level):
  - Level 0: pin constantly 0.
  - Level 255: pin constantly 1 (full on, no 1/256 gap).
  - Otherwise: pin = 1 when pwm_cnt < Level_Out.
  - Duty at level L = L/256 for 1 <= L <= 254.
- Step counter: 28-bit, counts 0..RAMP_STEP-1 only while in RAMP_UP or RAMP_DOWN. It is cleared on every state transition.
- State machine (Busy = 1 only in RAMP_UP and RAMP_DOWN):
  - OFF (level 0): LED_Req = 1 -> RAMP_UP.
  - RAMP_UP:
    - When the step counter reaches RAMP_STEP-1: level +1 and step counter -> 0.
    - If the level becomes 255 -> ON.
    - LED_Req = 0 in any cycle -> RAMP_DOWN immediately from the current level, with no level jump.
  - ON (level 255): LED_Req = 0 -> RAMP_DOWN.
  - RAMP_DOWN:
    - Mirror of RAMP_UP: level -1 per RAMP_STEP cycles.
    - If the level becomes 0 -> OFF.
    - LED_Req = 1 -> RAMP_UP from the current level.
- Level arithmetic saturates: the level never wraps past 0 or 255.
- First level change timing: the level changes exactly RAMP_STEP cycles after the cycle in which the state entered a ramp.
- Simultaneous events: if LED_Req toggles in the same cycle a step completes, the direction change wins. The level is not updated that cycle and the step counter clears.
- Request pulses shorter than one step: the FSM enters the ramp and leaves it with the level unchanged. It returns to OFF/ON on the next cycle.
- LED_Req is not synchronised internally, because it comes from same-clock logic.

Decomposition:
- Shared package led_pkg holds:
  - FSM state encoding: OFF=2'd0, RAMP_UP=2'd1, ON=2'd2, RAMP_DOWN=2'd3.
  - PWM_BITS default.
  - CLK_HZ = 50_000_000.
  - Derived constants (e.g., ONE_SEC = CLK_HZ) reused by the pattern generators.
- One sub-module, led_pwm:
  - Contains the free-running counter, the compare and the 0/255 special cases.
  - Inputs: CLK, RSTn, level. Output: registered pin.
  - The parent keeps the FSM and step counter.

Test Plan:
- Reset: hold RSTn=0 with LED_Req=1 -> LED_Pin=0, Level_Out=0, Busy=0. After release, state enters RAMP_UP on the first edge.
- Full ramp up (RAMP_STEP=4): LED_Req 0->1 -> Level_Out increments every 4 cycles, reaching 255 after 1020 cycles. Busy then falls to 0 and LED_Pin is a constant 1.
- PWM duty: with Level_Out held at 64 (LED_Req=1, ramp frozen by forcing RAMP_STEP large), count LED_Pin highs over 256 cycles -> exactly 64.
- Mid-ramp reversal (RAMP_STEP=4): raise LED_Req, drop it when Level_Out=10 -> level never exceeds 10. It decrements to 0 after 40 more cycles, then state=OFF and Busy=0.
- Simultaneous event: drop LED_Req in the exact cycle the step counter = RAMP_STEP-1 -> level holds its value that cycle, and the first decrement occurs RAMP_STEP cycles later.
- Async reset mid-ramp: assert RSTn=0 between clock edges at Level_Out=100 -> outputs clear immediately, without waiting for a CLK edge.
